arbitro_memoria_dados: RTL

Two-port arbiter that shares the single-ported data memory between the processor's load/store path and an external requester (program loader / debug port). It grants at most one access per cycle. It tracks which port owns the one-cycle read return and stalls the processor while the memory is unavailable to it. It sits between the core's load/store signals and the data memory.

---
 rtl/arbitro_memoria_dados_if.sv | 51 +++++
 rtl/arbitro_memoria_dados.sv | 106 ++++++++++
 2 files changed

// File: rtl/arbitro_memoria_dados_if.sv
// Bus bundle between the two requesters (processor load/store path and external
// loader/debug port), the data memory, and the arbiter that shares it.
interface arbitro_memoria_dados_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // Handshake: a requester raises x_req with x_we/x_addr/x_wdata and holds them
   // stable until the cycle x_gnt=1 (combinational accept). A granted read returns
   // on x_rdata with a one-cycle x_rvalid pulse exactly one cycle after that grant.
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_stall;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;

   logic              ext_req;
   logic              ext_we;
   logic [ADDR_W-1:0] ext_addr;
   logic [DATA_W-1:0] ext_wdata;
   logic              ext_lock;
   logic              ext_gnt;
   logic              ext_rvalid;
   logic [DATA_W-1:0] ext_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
      input  ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
      output ext_gnt, ext_rvalid, ext_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
      output ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
      input  ext_gnt, ext_rvalid, ext_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/arbitro_memoria_dados.sv
// Shares the single-ported data memory between the processor and an external
// requester: round-robin with an ext burst lock bounded by LOCK_MAX grants.
module arbitro_memoria_dados #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int LOCK_MAX = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   arbitro_memoria_dados_if.slave  bus,
   output logic [0:0]              fsm_state
);
   localparam logic [0:0] ST_RR       = 1'b0;
   localparam logic [0:0] ST_EXT_LOCK = 1'b1;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_CPU  = 2'd1;
   localparam logic [1:0] OWN_EXT  = 2'd2;

   localparam logic [3:0] LMAX = 4'(LOCK_MAX);

   logic [0:0] state;
   logic       pref;
   logic [3:0] lcnt;
   logic [1:0] rown;

   logic lock_exit;
   logic hold_ext;
   logic pref_eff;
   logic cpu_g;
   logic ext_g;

   // The exit cycle itself is arbitrated as a round-robin cycle with cpu preferred.
   assign lock_exit = (state == ST_EXT_LOCK) &&
                      (!bus.ext_lock || !bus.ext_req || ((lcnt == LMAX) && bus.cpu_req));
   assign hold_ext  = (state == ST_EXT_LOCK) && !lock_exit;
   assign pref_eff  = (state == ST_EXT_LOCK) ? 1'b0 : pref;

   always_comb begin
      cpu_g = 1'b0;
      ext_g = 1'b0;
      if (hold_ext) begin
         ext_g = 1'b1;
      end else if (bus.cpu_req && bus.ext_req) begin
         if (pref_eff) ext_g = 1'b1;
         else          cpu_g = 1'b1;
      end else if (bus.cpu_req) begin
         cpu_g = 1'b1;
      end else if (bus.ext_req) begin
         ext_g = 1'b1;
      end
   end

   always_comb begin
      bus.mem_en    = cpu_g | ext_g;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (cpu_g) begin
         bus.mem_we    = bus.cpu_we;
         bus.mem_addr  = bus.cpu_addr;
         bus.mem_wdata = bus.cpu_wdata;
      end else if (ext_g) begin
         bus.mem_we    = bus.ext_we;
         bus.mem_addr  = bus.ext_addr;
         bus.mem_wdata = bus.ext_wdata;
      end
   end

   assign bus.cpu_gnt    = cpu_g;
   assign bus.ext_gnt    = ext_g;
   assign bus.cpu_stall  = bus.cpu_req & ~cpu_g;
   assign bus.cpu_rvalid = (rown == OWN_CPU);
   assign bus.ext_rvalid = (rown == OWN_EXT);
   assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;
   assign bus.ext_rdata  = bus.ext_rvalid ? bus.mem_rdata : '0;
   assign fsm_state      = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RR;
         pref  <= 1'b0;
         lcnt  <= 4'd0;
         rown  <= OWN_NONE;
      end else begin
         if (cpu_g && !bus.cpu_we)      rown <= OWN_CPU;
         else if (ext_g && !bus.ext_we) rown <= OWN_EXT;
         else                           rown <= OWN_NONE;

         // Counter saturates while ext keeps the lock with the cpu idle.
         if (hold_ext) begin
            if (lcnt != LMAX) lcnt <= lcnt + 4'd1;
         end else if (ext_g && bus.ext_lock) begin
            state <= ST_EXT_LOCK;
            lcnt  <= 4'd1;
         end else begin
            state <= ST_RR;
            lcnt  <= 4'd0;
         end

         if (cpu_g)                     pref <= 1'b1;
         else if (ext_g)                pref <= 1'b0;
         else if (state == ST_EXT_LOCK) pref <= 1'b0;
      end
   end
endmodule
